i2c_regfile_ctrl: RTL
=====================

// Module: i2c_regfile_ctrl
// PURPOSE
//  Sequencing controller for i2c_simple_slave. Turns its byte strobes into a register-file protocol:
//  - first byte after a write-address is a register pointer; later bytes write registers with pointer auto-increment.
//  - reads stream registers from the pointer.
//  Drives the slave's stall input to stretch SCL while a write commits. Sits between the slave and user logic.
// PARAMETERS
//  I2C_ADDRESS    7'h42  7-bit address this controller answers to (must match the slave's i2c_address)
//  ADDR_W         4      pointer width; NUM_REGS = 2**ADDR_W (localparam)
//  COMMIT_CYCLES  2      stall cycles per written byte, range 1..15
// PORTS
//  clk                    in   1         system clock
//  rst                    in   1         reset, asynchronous, active-high
//  i2c_addr_rw            in   8         from slave: {addr[6:0], r/w}
//  i2c_addr_rw_valid_stb  in   1         from slave: address byte captured (fires for any address)
//  i2c_data_rx            in   8         from slave: received data byte
//  i2c_data_rx_valid_stb  in   1         from slave: data byte valid
//  i2c_data_tx_loaded_stb in   1         from slave: i2c_data_tx sampled into shifter
//  i2c_error_stb          in   1         from slave: protocol error
//  i2c_data_tx            out  8         to slave: next byte to transmit (registered)
//  stall                  out  1         to slave: clock-stretch request (registered)
//  regs_flat              out  8*NUM_REGS  register contents, reg n at [8n+7:8n]
//  wr_stb                 out  1         1-cycle pulse: register written
//  wr_addr                out  ADDR_W    address of write (valid with wr_stb)
//  wr_data                out  8         data of write (valid with wr_stb)
//  ptr                    out  ADDR_W    current register pointer
// BEHAVIOUR
//  - Clock and reset: one clock clk. rst is asynchronous and active-high.
//  - Reset values: all outputs 0, regs 0, state S_IDLE, commit counter 0.
//  - States: S_IDLE, S_PTR, S_WRITE, S_COMMIT, S_READ.
//  - Strobe priority: i2c_error_stb > i2c_addr_rw_valid_stb > rx/tx strobes.
//  - i2c_error_stb, any state: next cycle S_IDLE, stall=0, ptr retained.
//  - i2c_addr_rw_valid_stb, any state (covers repeated start):
//    - addr[7:1] != I2C_ADDRESS: go to S_IDLE.
//    - r/w=0: go to S_PTR.
//    - r/w=1: go to S_READ; i2c_data_tx <= regs[ptr] on the same edge.
//  - S_PTR, rx strobe: ptr <= rx[ADDR_W-1:0] (upper bits ignored), go to S_WRITE, no register write.
//  - S_WRITE, rx strobe: on the same edge:
//    - regs[ptr] <= rx; wr_stb=1 with wr_addr=ptr, wr_data=rx.
//    - ptr <= ptr+1, mod NUM_REGS (wraps 15->0).
//    - go to S_COMMIT with stall <= 1.
//  - S_COMMIT: stall held for exactly COMMIT_CYCLES cycles, then stall <= 0 and go to S_WRITE.
//    - rx strobe in S_COMMIT: handled as in S_WRITE and restarts the count.
//  - S_READ, tx_loaded strobe:
//    - ptr <= ptr+1 (wrap).
//    - i2c_data_tx <= regs[ptr+1] on the same edge, so the next byte is valid 1 cycle after the strobe.
//  - rx strobes in S_IDLE/S_READ and tx strobes outside S_READ are ignored.
//  - No stop indication is needed: a state persists until the next address or error strobe.
//  - Slave stall timing: the slave samples stall only in its S_STALL, after ACK. COMMIT_CYCLES may expire earlier; no overlap is required.
// CONFIGURATION
//  I2C_REGFILE_LOCK_EN
//   Defined:
//    - regs[0][7] is a lock bit; reg 0 is always writable.
//    - While lock=1, writes to regs 1..NUM_REGS-1 are dropped: no regs update, no wr_stb, no S_COMMIT/stall.
//    - A dropped write still increments ptr.
//   Undefined: all registers writable; regs[0][7] is plain storage.
// TESTING
//  1. Write 0x84, 0x03, 0xA5, 0x5A -> regs[3]=A5, regs[4]=5A, two wr_stb; stall=1 for 2 cycles after each data strobe; ptr=5.
//  2. After 1: write 0x84,0x03 then addr 0x85, then tx_loaded twice -> i2c_data_tx=A5 at addr+1; 5A 1 cycle after 1st tx_loaded; ptr=5.
//  3. Write 0x84, 0x0F, 0x11, 0x22 -> regs[15]=11, regs[0]=22, ptr=1 (wrap).
//  4. Addr 0x86 (0x43), then rx 0x00, 0x77 -> no regs change, no wr_stb, stall stays 0.
//  5. Write 0x84, 0x02, 0x99; assert i2c_error_stb in 1st S_COMMIT cycle -> stall=0 next cycle; state S_IDLE; regs[2]=99.
//  6. LOCK_EN: write 0x84, 0x00, 0x80, 0x44 -> regs[0]=80, regs[1] unchanged, one wr_stb, ptr=2.

Source files
------------

// File: rtl/i2c_regfile_ctrl.sv
// Register-file sequencer for i2c_simple_slave: pointer byte, auto-increment writes with
// SCL stretch per commit, streaming reads. Optional write lock via I2C_REGFILE_LOCK_EN.
module i2c_regfile_ctrl #(
  parameter logic [6:0] I2C_ADDRESS   = 7'h42,
  parameter int         ADDR_W        = 4,
  parameter int         COMMIT_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   i2c_addr_rw,
  input  logic                         i2c_addr_rw_valid_stb,
  input  logic [7:0]                   i2c_data_rx,
  input  logic                         i2c_data_rx_valid_stb,
  input  logic                         i2c_data_tx_loaded_stb,
  input  logic                         i2c_error_stb,
  output logic [7:0]                   i2c_data_tx,
  output logic                         stall,
  output logic [8*(2**ADDR_W)-1:0]     regs_flat,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [7:0]                   wr_data,
  output logic [ADDR_W-1:0]            ptr
);

  localparam int         NUM_REGS = 2**ADDR_W;
  localparam logic [3:0] CNT_LAST = 4'(COMMIT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_PTR, S_WRITE, S_COMMIT, S_READ} state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_ptr, w_ptr_next, w_ptr_inc;
  logic [3:0]          r_cnt, w_cnt_next;
  logic [7:0]          r_tx, w_tx_next;
  logic [7:0]          r_regs [NUM_REGS];
  logic                r_stall;
  logic                r_wr_stb;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [7:0]          r_wr_data;
  logic                w_we;
  logic                w_locked;

  assign w_ptr_inc = r_ptr + 1'b1;

`ifdef I2C_REGFILE_LOCK_EN
  // Bit 7 of reg 0 freezes every register except reg 0 itself.
  assign w_locked = r_regs[0][7] && (r_ptr != '0);
`else
  assign w_locked = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    w_tx_next    = r_tx;
    w_we         = 1'b0;
    if (i2c_error_stb) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end else if (i2c_addr_rw_valid_stb) begin
      w_cnt_next = '0;
      if (i2c_addr_rw[7:1] != I2C_ADDRESS) begin
        w_state_next = S_IDLE;
      end else if (i2c_addr_rw[0]) begin
        w_state_next = S_READ;
        w_tx_next    = r_regs[r_ptr];
      end else begin
        w_state_next = S_PTR;
      end
    end else begin
      case (r_state)
        S_PTR: begin
          if (i2c_data_rx_valid_stb) begin
            w_ptr_next   = i2c_data_rx[ADDR_W-1:0];
            w_state_next = S_WRITE;
          end
        end
        S_WRITE: begin
          if (i2c_data_rx_valid_stb) begin
            w_ptr_next = w_ptr_inc;
            if (!w_locked) begin
              w_we         = 1'b1;
              w_state_next = S_COMMIT;
              w_cnt_next   = '0;
            end
          end
        end
        S_COMMIT: begin
          // A new accepted byte restarts the stretch; a dropped one only moves the pointer.
          if (i2c_data_rx_valid_stb && !w_locked) begin
            w_we       = 1'b1;
            w_ptr_next = w_ptr_inc;
            w_cnt_next = '0;
          end else begin
            if (i2c_data_rx_valid_stb) w_ptr_next = w_ptr_inc;
            if (r_cnt == CNT_LAST) begin
              w_state_next = S_WRITE;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt + 4'd1;
            end
          end
        end
        S_READ: begin
          if (i2c_data_tx_loaded_stb) begin
            w_ptr_next = w_ptr_inc;
            w_tx_next  = r_regs[w_ptr_inc];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_tx      <= '0;
      r_stall   <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ptr    <= w_ptr_next;
      r_cnt    <= w_cnt_next;
      r_tx     <= w_tx_next;
      r_stall  <= (w_state_next == S_COMMIT);
      r_wr_stb <= w_we;
      if (w_we) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= i2c_data_rx;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_regs[gi] <= '0;
        end else if (w_we && (r_ptr == ADDR_W'(gi))) begin
          r_regs[gi] <= i2c_data_rx;
        end
      end
      assign regs_flat[8*gi +: 8] = r_regs[gi];
    end
  endgenerate

  assign i2c_data_tx = r_tx;
  assign stall       = r_stall;
  assign wr_stb      = r_wr_stb;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign ptr         = r_ptr;

endmodule
